// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares a single-port framebuffer RAM between VGA scan-out and a CPU bus.
// One display read is issued for every 4x4-scaled framebuffer pixel (the
// first column of each 4-column group inside the active region); every other
// cycle is available to the CPU. Display always wins a collision, so a CPU
// request waits at most one cycle for its grant. Fetched words are held in a
// pixel register and shown as 4-bit RGB with a fixed 2-cycle latency relative
// to the h/v counters.
//
// Ports
//   pxl_clk, rst          : clock, synchronous active-high reset
//   h_count, v_count      : scan position from the timing generator
//   red, green, blue      : pixel for the counters presented 2 cycles earlier
//   cpu_req/we/addr/wdata : CPU request, held stable until cpu_ack
//   cpu_ack, cpu_rdata    : one-cycle completion pulse and read data
//   ram_en/we/addr/wdata  : RAM strobe, write enable, address, write data
//   ram_rdata             : RAM read data, valid the cycle after ram_en
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 15
) (
    input  logic              pxl_clk,
    input  logic              rst,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [11:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [11:0]       cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [11:0]       ram_wdata,
    input  logic [11:0]       ram_rdata
);

    localparam logic [9:0]        H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]        V_ACT    = 10'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(FB_W * FB_H);

    typedef enum logic [1:0] {
        CPU_IDLE = 2'd0,
        CPU_WAIT = 2'd1,
        CPU_ACK  = 2'd2
    } cpu_state_e;

    logic              active;
    logic              disp_slot;
    logic              cpu_in_range;
    logic              cpu_grant;
    logic [ADDR_W-1:0] fb_x;
    logic [ADDR_W-1:0] fb_y;
    logic [ADDR_W-1:0] disp_addr;

    cpu_state_e        state_q, state_d;
    logic [11:0]       cpu_rdata_q, cpu_rdata_d;
    logic              cpu_rd_q, cpu_rd_d;     // last grant was an in-range read
    logic              owner_disp_q;           // last cycle's RAM slot belonged to display
    logic [1:0]        active_q;               // active flag delayed by 1 and 2 cycles
    logic [11:0]       pixel_q, pixel_d;

    // -----------------------------------------------------------------------
    // Scan position decode
    // -----------------------------------------------------------------------
    assign active    = (h_count < H_ACT) && (v_count < V_ACT);
    assign disp_slot = active && (h_count[SCALE_LOG2-1:0] == '0);

    assign fb_x = ADDR_W'(h_count >> SCALE_LOG2);
    assign fb_y = ADDR_W'(v_count >> SCALE_LOG2);

    generate
        if (FB_W == 160) begin : g_addr_shift
            // y*160 = y*128 + y*32, avoiding a multiplier
            assign disp_addr = (fb_y << 7) + (fb_y << 5) + fb_x;
        end else begin : g_addr_mul
            assign disp_addr = fb_y * ADDR_W'(FB_W) + fb_x;
        end
    endgenerate

    assign cpu_in_range = (cpu_addr < FB_WORDS);

    // -----------------------------------------------------------------------
    // CPU access FSM: IDLE (grant) -> WAIT (capture) -> ACK (pulse)
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        cpu_grant   = 1'b0;
        cpu_rd_d    = 1'b0;
        cpu_rdata_d = cpu_rdata_q;

        case (state_q)
            CPU_IDLE: begin
                if (cpu_req && !disp_slot) begin
                    cpu_grant = 1'b1;
                    cpu_rd_d  = cpu_in_range && !cpu_we;
                    state_d   = CPU_WAIT;
                end
            end
            CPU_WAIT: begin
                // Out-of-range reads and writes return zero
                cpu_rdata_d = (cpu_rd_q && !owner_disp_q) ? ram_rdata : '0;
                state_d     = CPU_ACK;
            end
            CPU_ACK: begin
                state_d = CPU_IDLE;
            end
            default: begin
                state_d = CPU_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // RAM port steering; display has priority, out-of-range CPU grants
    // complete the handshake without touching the RAM
    // -----------------------------------------------------------------------
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst) begin
            if (disp_slot) begin
                ram_en   = 1'b1;
                ram_addr = disp_addr;
            end else if (cpu_grant && cpu_in_range) begin
                ram_en    = 1'b1;
                ram_we    = cpu_we;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end
        end
    end

    // Pixel register takes the word returned for the previous display read
    assign pixel_d = owner_disp_q ? ram_rdata : pixel_q;

    always_ff @(posedge pxl_clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= CPU_IDLE;
            cpu_rdata_q  <= '0;
            cpu_rd_q     <= 1'b0;
            owner_disp_q <= 1'b0;
            active_q     <= '0;
            pixel_q      <= '0;
        end else begin
            state_q      <= state_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rd_q     <= cpu_rd_d;
            owner_disp_q <= disp_slot;
            active_q     <= {active_q[0], active};
            pixel_q      <= pixel_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cpu_ack   = (state_q == CPU_ACK) && !rst;
    assign cpu_rdata = cpu_rdata_q;

    // Blank using the active flag aligned with the 2-cycle pixel pipeline
    assign {red, green, blue} = active_q[1] ? pixel_q : 12'h000;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_arbiter
//
// Self-checking bench for vga_fb_arbiter: a reset sequence, a table of
// consecutive-cycle vectors for display fetch, CPU write/read, out-of-range,
// collision and blanking, a mid-transaction reset, and a randomized scan with
// random CPU traffic checked against a history-based reference model.
// ---------------------------------------------------------------------------
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 15;

    logic              pxl_clk = 1'b0;
    logic              rst;
    logic [9:0]        h_count;
    logic [9:0]        v_count;
    logic [3:0]        red, green, blue;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [11:0]       cpu_wdata;
    logic              cpu_ack;
    logic [11:0]       cpu_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [11:0]       ram_wdata;
    logic [11:0]       ram_rdata;

    vga_fb_arbiter dut (
        .pxl_clk   (pxl_clk),
        .rst       (rst),
        .h_count   (h_count),
        .v_count   (v_count),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 pxl_clk = ~pxl_clk;

    // -----------------------------------------------------------------------
    // Synchronous single-port RAM model, with an override for directed data
    // -----------------------------------------------------------------------
    logic [11:0] ram_mem [0:32767];
    logic [11:0] ram_q;
    logic        mem_clr;
    logic        frc;
    logic [11:0] frd;

    always @(posedge pxl_clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32768; i++) ram_mem[i] <= '0;
            ram_q <= '0;
        end else if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_q <= ram_mem[ram_addr];
        end
    end

    assign ram_rdata = frc ? frd : ram_q;

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag,
                                 input logic e_en, input logic e_we,
                                 input logic [14:0] e_addr, input logic [11:0] e_wdata,
                                 input logic e_ack, input logic chk_rd,
                                 input logic [11:0] e_rd, input logic [11:0] e_rgb);
        check({tag, " ram_en"},    32'(ram_en),    32'(e_en));
        check({tag, " ram_we"},    32'(ram_we),    32'(e_we));
        check({tag, " ram_addr"},  32'(ram_addr),  32'(e_addr));
        check({tag, " ram_wdata"}, 32'(ram_wdata), 32'(e_wdata));
        check({tag, " cpu_ack"},   32'(cpu_ack),   32'(e_ack));
        check({tag, " rgb"},       32'({red, green, blue}), 32'(e_rgb));
        if (chk_rd) check({tag, " cpu_rdata"}, 32'(cpu_rdata), 32'(e_rd));
    endtask

    // -----------------------------------------------------------------------
    // Directed vector table: one record per consecutive clock cycle
    // -----------------------------------------------------------------------
    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        req;
        logic        we;
        logic [14:0] addr;
        logic [11:0] wdata;
        logic        frc;
        logic [11:0] frd;
        logic        e_en;
        logic        e_we;
        logic [14:0] e_addr;
        logic [11:0] e_wdata;
        logic        e_ack;
        logic        chk_rd;
        logic [11:0] e_rd;
        logic [11:0] e_rgb;
    } vec_t;

    function automatic vec_t mk(input int h, input int v, input int req, input int we,
                                input int addr, input int wdata, input int frc_i, input int frd_i,
                                input int en, input int ewe, input int eaddr, input int ewd,
                                input int ack, input int chk, input int erd, input int rgb);
        vec_t r;
        r.h = 10'(h);        r.v = 10'(v);
        r.req = 1'(req);     r.we = 1'(we);
        r.addr = 15'(addr);  r.wdata = 12'(wdata);
        r.frc = 1'(frc_i);   r.frd = 12'(frd_i);
        r.e_en = 1'(en);     r.e_we = 1'(ewe);
        r.e_addr = 15'(eaddr); r.e_wdata = 12'(ewd);
        r.e_ack = 1'(ack);   r.chk_rd = 1'(chk);
        r.e_rd = 12'(erd);   r.e_rgb = 12'(rgb);
        return r;
    endfunction

    vec_t tbl[$];

    // -----------------------------------------------------------------------
    // Reference model state for the randomized phase
    // -----------------------------------------------------------------------
    localparam int RND_SEG    = 1500;
    localparam int RND_CYCLES = 3 * RND_SEG;

    logic [11:0] model_mem [0:32767];
    bit          act_hist [0:RND_CYCLES-1];
    logic [11:0] lf_hist  [0:RND_CYCLES-1];

    int          hh, vv, cyc, grant_cyc, sel;
    bit          outstanding, req_on, g_rd, m_active, m_disp, m_ack;
    logic [11:0] last_fetch, g_val;
    logic        r_we;
    logic [14:0] r_addr;
    logic [11:0] r_wdata;
    logic        m_en, m_we;
    logic [14:0] m_addr;
    logic [11:0] m_wdata, m_rgb;

    initial begin
        // ---------------- reset: rst held 3 cycles with a pending request
        rst = 1'b1; mem_clr = 1'b1;
        h_count = 10'd4; v_count = 10'd8;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd5; cpu_wdata = 12'hFFF;
        frc = 1'b0; frd = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pxl_clk);
            check_outputs($sformatf("reset%0d", i), 0, 0, 0, 0, 0, 1, 0, 0);
            @(posedge pxl_clk); #1;
        end
        rst = 1'b0; mem_clr = 1'b0;

        // ---------------- directed table
        //            h    v   req we addr   wdata   frc frd     en we eaddr ewd   ack chk erd     rgb
        tbl.push_back(mk(4,   8,   0, 0, 0,     0,      0, 0,      1, 0, 321,  0,     0, 0, 0,      0));
        tbl.push_back(mk(5,   8,   0, 0, 0,     0,      1, 'hA5C,  0, 0, 0,    0,     0, 0, 0,      0));
        tbl.push_back(mk(6,   8,   0, 0, 0,     0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      'hA5C));
        tbl.push_back(mk(7,   8,   0, 0, 0,     0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      'hA5C));
        tbl.push_back(mk(8,   8,   0, 0, 0,     0,      0, 0,      1, 0, 322,  0,     0, 0, 0,      'hA5C));
        tbl.push_back(mk(9,   8,   0, 0, 0,     0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      'hA5C));
        tbl.push_back(mk(10,  8,   0, 0, 0,     0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      0));
        // CPU write in vertical blanking
        tbl.push_back(mk(10,  500, 1, 1, 100,   'h123,  0, 0,      1, 1, 100,  'h123, 0, 0, 0,      0));
        tbl.push_back(mk(11,  500, 1, 1, 100,   'h123,  0, 0,      0, 0, 0,    0,     0, 0, 0,      0));
        tbl.push_back(mk(12,  500, 1, 1, 100,   'h123,  0, 0,      0, 0, 0,    0,     1, 0, 0,      0));
        tbl.push_back(mk(13,  500, 0, 0, 0,     0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      0));
        // read-back
        tbl.push_back(mk(14,  500, 1, 0, 100,   0,      0, 0,      1, 0, 100,  0,     0, 0, 0,      0));
        tbl.push_back(mk(15,  500, 1, 0, 100,   0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      0));
        tbl.push_back(mk(16,  500, 1, 0, 100,   0,      0, 0,      0, 0, 0,    0,     1, 1, 'h123,  0));
        tbl.push_back(mk(17,  500, 0, 0, 0,     0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      0));
        // out-of-range read: no RAM access, ack with zero data
        tbl.push_back(mk(18,  500, 1, 0, 19200, 0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      0));
        tbl.push_back(mk(19,  500, 1, 0, 19200, 0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      0));
        tbl.push_back(mk(20,  500, 1, 0, 19200, 0,      0, 0,      0, 0, 0,    0,     1, 1, 0,      0));
        tbl.push_back(mk(21,  500, 0, 0, 0,     0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      0));
        // out-of-range write: dropped
        tbl.push_back(mk(22,  500, 1, 1, 20000, 'hFFF,  0, 0,      0, 0, 0,    0,     0, 0, 0,      0));
        tbl.push_back(mk(23,  500, 1, 1, 20000, 'hFFF,  0, 0,      0, 0, 0,    0,     0, 0, 0,      0));
        tbl.push_back(mk(24,  500, 1, 1, 20000, 'hFFF,  0, 0,      0, 0, 0,    0,     1, 0, 0,      0));
        tbl.push_back(mk(25,  500, 0, 0, 0,     0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      0));
        // collision at (0,0): display first, CPU one cycle later
        tbl.push_back(mk(0,   0,   1, 0, 100,   0,      0, 0,      1, 0, 0,    0,     0, 0, 0,      0));
        tbl.push_back(mk(1,   0,   1, 0, 100,   0,      1, 'h3C7,  1, 0, 100,  0,     0, 0, 0,      0));
        tbl.push_back(mk(2,   0,   1, 0, 100,   0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      'h3C7));
        tbl.push_back(mk(3,   0,   1, 0, 100,   0,      0, 0,      0, 0, 0,    0,     1, 1, 'h123,  'h3C7));
        tbl.push_back(mk(4,   0,   0, 0, 0,     0,      0, 0,      1, 0, 1,    0,     0, 0, 0,      'h3C7));
        // horizontal blanking with all-ones RAM data
        tbl.push_back(mk(640, 0,   0, 0, 0,     0,      1, 'hFFF,  0, 0, 0,    0,     0, 0, 0,      'h3C7));
        tbl.push_back(mk(641, 0,   0, 0, 0,     0,      1, 'hFFF,  0, 0, 0,    0,     0, 0, 0,      'hFFF));
        tbl.push_back(mk(642, 0,   0, 0, 0,     0,      1, 'hFFF,  0, 0, 0,    0,     0, 0, 0,      0));
        tbl.push_back(mk(643, 0,   0, 0, 0,     0,      1, 'hFFF,  0, 0, 0,    0,     0, 0, 0,      0));
        tbl.push_back(mk(799, 0,   0, 0, 0,     0,      1, 'hFFF,  0, 0, 0,    0,     0, 0, 0,      0));
        tbl.push_back(mk(798, 0,   0, 0, 0,     0,      1, 'hFFF,  0, 0, 0,    0,     0, 0, 0,      0));
        // last framebuffer word and the active-region edges
        tbl.push_back(mk(636, 479, 0, 0, 0,     0,      0, 0,      1, 0, 19199,0,     0, 0, 0,      0));
        tbl.push_back(mk(637, 479, 0, 0, 0,     0,      1, 'h5A5,  0, 0, 0,    0,     0, 0, 0,      0));
        tbl.push_back(mk(638, 479, 0, 0, 0,     0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      'h5A5));
        tbl.push_back(mk(639, 479, 0, 0, 0,     0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      'h5A5));
        tbl.push_back(mk(640, 479, 0, 0, 0,     0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      'h5A5));
        tbl.push_back(mk(0,   480, 0, 0, 0,     0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      'h5A5));
        tbl.push_back(mk(1,   480, 0, 0, 0,     0,      0, 0,      0, 0, 0,    0,     0, 0, 0,      0));

        for (int i = 0; i < tbl.size(); i++) begin
            h_count = tbl[i].h;   v_count = tbl[i].v;
            cpu_req = tbl[i].req; cpu_we = tbl[i].we;
            cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata;
            frc = tbl[i].frc;     frd = tbl[i].frd;
            @(negedge pxl_clk);
            check_outputs($sformatf("vec%0d", i), tbl[i].e_en, tbl[i].e_we, tbl[i].e_addr,
                          tbl[i].e_wdata, tbl[i].e_ack, tbl[i].chk_rd, tbl[i].e_rd, tbl[i].e_rgb);
            @(posedge pxl_clk); #1;
        end
        frc = 1'b0;

        // ---------------- reset in the middle of a CPU write: no ack follows
        h_count = 10'd100; v_count = 10'd500;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd7; cpu_wdata = 12'h0AB;
        @(negedge pxl_clk);
        check("midrst grant ram_en", 32'(ram_en), 32'd1);
        check("midrst grant ram_addr", 32'(ram_addr), 32'd7);
        @(posedge pxl_clk); #1;
        rst = 1'b1;
        @(negedge pxl_clk);
        check("midrst in-reset cpu_ack", 32'(cpu_ack), 32'd0);
        @(posedge pxl_clk); #1;
        rst = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pxl_clk);
            check($sformatf("midrst after%0d cpu_ack", i), 32'(cpu_ack), 32'd0);
            @(posedge pxl_clk); #1;
        end

        // ---------------- randomized scan with random CPU traffic
        for (int i = 0; i < 32768; i++) model_mem[i] = '0;
        model_mem[100] = 12'h123;
        model_mem[7]   = 12'h0AB;

        rst = 1'b1; h_count = 10'd700; v_count = 10'd500; cpu_req = 1'b0;
        repeat (3) begin @(posedge pxl_clk); #1; end
        rst = 1'b0;

        outstanding = 0; req_on = 0; last_fetch = '0; cyc = 0; grant_cyc = 0;
        g_rd = 0; g_val = '0; r_we = 0; r_addr = '0; r_wdata = '0;
        for (int seg = 0; seg < 3; seg++) begin
            case (seg)
                0:       begin hh = 560; vv = 476; end
                1:       begin hh = 700; vv = 524; end
                default: begin hh = 120; vv = 30;  end
            endcase
            for (int k = 0; k < RND_SEG; k++) begin
                if (!req_on && $urandom_range(0, 3) == 0) begin
                    req_on  = 1;
                    r_we    = 1'($urandom_range(0, 1));
                    r_wdata = 12'($urandom);
                    sel     = int'($urandom_range(0, 3));
                    case (sel)
                        0:       r_addr = 15'($urandom_range(0, 319));
                        1:       r_addr = 15'($urandom_range(19040, 19199));
                        2:       r_addr = 15'($urandom_range(19200, 32767));
                        default: r_addr = 15'($urandom_range(0, 31));
                    endcase
                end

                m_active = (hh < 640) && (vv < 480);
                m_disp   = m_active && (hh % 4 == 0);
                m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
                m_ack = outstanding && (cyc == grant_cyc + 2);

                if (m_disp) begin
                    m_en       = 1;
                    m_addr     = 15'((vv / 4) * 160 + hh / 4);
                    last_fetch = model_mem[m_addr];
                end else if (req_on && !outstanding) begin
                    outstanding = 1;
                    grant_cyc   = cyc;
                    g_rd        = !r_we;
                    g_val       = '0;
                    if (r_addr < 15'd19200) begin
                        m_en = 1; m_we = r_we; m_addr = r_addr; m_wdata = r_wdata;
                        if (r_we) model_mem[r_addr] = r_wdata;
                        else      g_val = model_mem[r_addr];
                    end
                end

                act_hist[cyc] = m_active;
                lf_hist[cyc]  = last_fetch;
                m_rgb = (cyc >= 2 && act_hist[cyc-2]) ? lf_hist[cyc-2] : 12'h000;

                h_count = 10'(hh); v_count = 10'(vv);
                cpu_req = req_on; cpu_we = r_we; cpu_addr = r_addr; cpu_wdata = r_wdata;
                @(negedge pxl_clk);
                check_outputs($sformatf("rnd%0d", cyc), m_en, m_we, m_addr, m_wdata,
                              m_ack, m_ack && g_rd, g_val, m_rgb);
                if (m_ack) begin
                    outstanding = 0;
                    req_on      = 0;
                end
                @(posedge pxl_clk); #1;

                hh++;
                if (hh == 800) begin
                    hh = 0;
                    vv = (vv == 524) ? 0 : vv + 1;
                end
                cyc++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
